rle_expand: RTL and testbench

// - Run-length decoder, the inverse of the capture-path RLE encoder. Expands the stored

---
 rtl/rle_pkg.sv | 23 ++
 rtl/rle_expand_if.sv | 28 ++
 rtl/rle_expand.sv | 136 +++++++++++++
 tb/tb_rle_expand.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared run-length coding definitions used by both the capture-path encoder and
// the readback-path decoder, so both agree on word layout.
package rle_pkg;

  localparam int RLE_DW       = 16;
  localparam int RLE_SW       = RLE_DW - 1;
  localparam int RLE_FLAG_BIT = RLE_DW - 1;
  localparam int RLE_CNT_W    = 32;

  typedef enum logic {
    S_PASS,
    S_RUN
  } rle_state_e;

  function automatic logic rle_is_run(input logic [RLE_DW-1:0] word);
    return word[RLE_FLAG_BIT];
  endfunction

  function automatic logic [RLE_SW-1:0] rle_payload(input logic [RLE_DW-1:0] word);
    return word[RLE_SW-1:0];
  endfunction

endpackage

// File: rtl/rle_expand_if.sv
// Compressed-in / expanded-out stream pair of the run-length decoder.
// The master side feeds words and takes samples; the slave side is the decoder.
interface rle_expand_if
  import rle_pkg::*;
#(
  parameter int DW = RLE_DW,
  parameter int SW = RLE_SW
) ();

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_data;
  logic          out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/rle_expand.sv
// Run-length decoder on the readback path: turns the stored compressed stream back
// into one sample per output handshake, with an optional total-sample limit.
module rle_expand
  import rle_pkg::*;
#(
  parameter int DW    = RLE_DW,
  parameter int SW    = RLE_SW,
  parameter int CNT_W = RLE_CNT_W
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] sample_limit,
  rle_expand_if.slave      bus,
  output logic [CNT_W-1:0] out_cnt,
  output logic             done
);

  rle_state_e       state_q;
  logic [SW-1:0]    runCnt_q;
  logic [SW-1:0]    lastSample_q;
  logic             outValid_q;
  logic [SW-1:0]    outData_q;
  logic             outLast_q;
  logic [CNT_W-1:0] outCnt_q;
  logic             done_q;
  logic [CNT_W-1:0] limit_q;
  logic             limitLoad_q;

  logic [DW-1:0]    inWord;
  logic [SW-1:0]    inPayload;
  logic             free;
  logic             outHs;
  logic             inHs;
  logic             canLoad;
  logic             inReady;
  logic             hitLimit;
  logic [CNT_W-1:0] limit_d;
  logic [CNT_W-1:0] outCnt_d;
  logic [CNT_W-1:0] cntAfter;
  logic [CNT_W-1:0] cntAfterInc;
  logic             nextLast;

  assign inWord    = bus.in_data;
  assign inPayload = rle_payload(inWord);

  // A pending last sample blocks further loads, so nothing can slip in behind it.
  assign free     = ~outValid_q | bus.out_ready;
  assign outHs    = outValid_q & bus.out_ready;
  assign canLoad  = free & ~(outValid_q & outLast_q) & ~done_q;
  assign inReady  = ~core_rst & (state_q == S_PASS) & canLoad;
  assign inHs     = bus.in_valid & inReady;
  assign hitLimit = outHs & outLast_q;

  // The limit is captured on the first cycle after reset/clear; until then use the live port.
  assign limit_d     = limitLoad_q ? sample_limit : limit_q;
  assign outCnt_d    = (outCnt_q == '1) ? outCnt_q : outCnt_q + CNT_W'(1);
  assign cntAfter    = outHs ? outCnt_d : outCnt_q;
  assign cntAfterInc = (cntAfter == '1) ? cntAfter : cntAfter + CNT_W'(1);
  assign nextLast    = (limit_d != '0) && (cntAfterInc == limit_d);

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q      <= S_PASS;
      runCnt_q     <= '0;
      lastSample_q <= '0;
      outValid_q   <= 1'b0;
      outData_q    <= '0;
      outLast_q    <= 1'b0;
      outCnt_q     <= '0;
      done_q       <= 1'b0;
      limit_q      <= '0;
      limitLoad_q  <= 1'b1;
    end else if (clear) begin
      state_q      <= S_PASS;
      runCnt_q     <= '0;
      lastSample_q <= '0;
      outValid_q   <= 1'b0;
      outData_q    <= '0;
      outLast_q    <= 1'b0;
      outCnt_q     <= '0;
      done_q       <= 1'b0;
      limit_q      <= '0;
      limitLoad_q  <= 1'b1;
    end else begin
      if (limitLoad_q) begin
        limit_q     <= sample_limit;
        limitLoad_q <= 1'b0;
      end
      if (outHs) begin
        outCnt_q   <= outCnt_d;
        outValid_q <= 1'b0;
      end
      if (hitLimit) begin
        done_q    <= 1'b1;
        runCnt_q  <= '0;
        state_q   <= S_PASS;
        outLast_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_PASS: begin
            if (inHs) begin
              if (!rle_is_run(inWord)) begin
                outData_q    <= inPayload;
                lastSample_q <= inPayload;
                outValid_q   <= 1'b1;
                outLast_q    <= nextLast;
              end else if (inPayload != '0) begin
                runCnt_q <= inPayload;
                state_q  <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (canLoad) begin
              outData_q  <= lastSample_q;
              outValid_q <= 1'b1;
              outLast_q  <= nextLast;
              runCnt_q   <= runCnt_q - SW'(1);
              if (runCnt_q == SW'(1)) state_q <= S_PASS;
            end
          end
          default: state_q <= S_PASS;
        endcase
      end
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_last  = outLast_q;
  assign out_cnt       = outCnt_q;
  assign done          = done_q;

endmodule

// File: tb/tb_rle_expand.sv
// Bench for rle_expand: directed scenarios plus random word streams, all checked
// against a plain list-expansion model of the run-length format.
module tb_rle_expand;

  logic        core_clk = 1'b0;
  logic        core_rst;
  logic        clear;
  logic [31:0] sample_limit;
  logic [31:0] out_cnt;
  logic        done;

  rle_expand_if #(.DW(16), .SW(15)) bus ();

  rle_expand #(.DW(16), .SW(15), .CNT_W(32)) dut (
    .core_clk     (core_clk),
    .core_rst     (core_rst),
    .clear        (clear),
    .sample_limit (sample_limit),
    .bus          (bus),
    .out_cnt      (out_cnt),
    .done         (done)
  );

  always #5 core_clk = ~core_clk;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [15:0] inWords[$];
  logic [14:0] expData[$];
  bit          expLast[$];
  logic [14:0] gotData[$];
  bit          gotLast[$];
  int          inAccCycle[$];
  int          outHsCycle[$];
  int          readyLowCnt;
  int          stableErrs;
  int          sentCnt;
  bit          timedOut;

  // Reference: expand the word list literally, then cut it to the limit.
  function automatic void buildModel(input int limit);
    logic [14:0] last = '0;
    expData.delete();
    expLast.delete();
    foreach (inWords[k]) begin
      if (inWords[k][15]) begin
        for (int r = 0; r < int'(inWords[k][14:0]); r++) begin
          expData.push_back(last);
          expLast.push_back(1'b0);
        end
      end else begin
        last = inWords[k][14:0];
        expData.push_back(last);
        expLast.push_back(1'b0);
      end
    end
    if (limit != 0 && expData.size() >= limit) begin
      while (expData.size() > limit) begin
        void'(expData.pop_back());
        void'(expLast.pop_back());
      end
      expLast[limit-1] = 1'b1;
    end
  endfunction

  task automatic doReset(input logic [31:0] lim);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b1;
    sample_limit = lim;
    core_rst     = 1'b1;
    repeat (2) @(negedge core_clk);
    core_rst = 1'b0;
  endtask

  // Drives inWords and records every handshake; readyMode 0=always, 1=toggle, 2=random.
  task automatic applyStimulus(input int readyMode, input bit randValid);
    int idx = 0;
    int idle = 0;
    int cyc = 0;
    bit pend = 1'b0;
    logic [14:0] pd = '0;
    logic pl = 1'b0;
    gotData.delete(); gotLast.delete(); inAccCycle.delete(); outHsCycle.delete();
    readyLowCnt = 0; stableErrs = 0; timedOut = 1'b0;
    while (1) begin
      @(negedge core_clk);
      bus.in_valid = (idx < inWords.size()) && (!randValid || $urandom_range(0, 3) != 0);
      bus.in_data  = (idx < inWords.size()) ? inWords[idx] : 16'h0;
      case (readyMode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 2 == 0);
        default: bus.out_ready = ($urandom_range(0, 1) == 1);
      endcase
      #1;
      if (pend && (!bus.out_valid || bus.out_data !== pd || bus.out_last !== pl)) stableErrs++;
      pend = bus.out_valid && !bus.out_ready;
      pd   = bus.out_data;
      pl   = bus.out_last;
      if (!bus.in_ready) readyLowCnt++;
      if (bus.in_valid && bus.in_ready) begin
        if (!inWords[idx][15]) inAccCycle.push_back(cyc);
        idx++;
      end
      if (bus.out_valid && bus.out_ready) begin
        gotData.push_back(bus.out_data);
        gotLast.push_back(bus.out_last);
        outHsCycle.push_back(cyc);
        idle = 0;
      end else if (!bus.out_valid) idle++;
      else idle = 0;
      cyc++;
      if ((idx >= inWords.size() || done) && idle >= 5) break;
      if (cyc >= 3000) begin
        timedOut = 1'b1;
        break;
      end
    end
    sentCnt = idx;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    sample_limit  = 0;
    clear         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h0001;
    bus.out_ready = 1'b1;
    core_rst      = 1'b1;
    repeat (2) @(negedge core_clk);
    #1;
    nChecks++; if (bus.in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_in_ready got %0b want 0", bus.in_ready); end
    nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    nChecks++; if (bus.out_data !== 15'h0) begin nFails++; $display("[TB] FAIL reset_out_data got %0h want 0", bus.out_data); end
    nChecks++; if (bus.out_last !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_last got %0b want 0", bus.out_last); end
    nChecks++; if (out_cnt !== 32'd0) begin nFails++; $display("[TB] FAIL reset_out_cnt got %0d want 0", out_cnt); end
    nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done got %0b want 0", done); end
    bus.in_valid = 1'b0;
    @(negedge core_clk);
    core_rst = 1'b0;
    #1;
    nChecks++; if (bus.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL release_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_passthrough();
    doReset(0);
    inWords = '{16'h0001, 16'h0002, 16'h0003};
    buildModel(0);
    applyStimulus(0, 1'b0);
    nChecks++; if (gotData.size() != expData.size()) begin nFails++; $display("[TB] FAIL pass_count got %0d want %0d", gotData.size(), expData.size()); end
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      nChecks++; if (gotData[i] !== expData[i]) begin nFails++; $display("[TB] FAIL pass_data[%0d] got %0h want %0h", i, gotData[i], expData[i]); end
    end
    for (int i = 0; i < inAccCycle.size() && i < outHsCycle.size(); i++) begin
      nChecks++; if (outHsCycle[i] - inAccCycle[i] != 1) begin nFails++; $display("[TB] FAIL pass_latency[%0d] got %0d want 1", i, outHsCycle[i] - inAccCycle[i]); end
    end
    if (outHsCycle.size() == 3) begin
      nChecks++; if (outHsCycle[2] - outHsCycle[0] != 2) begin nFails++; $display("[TB] FAIL pass_consecutive got span %0d want 2", outHsCycle[2] - outHsCycle[0]); end
    end
    nChecks++; if (out_cnt !== 32'd3) begin nFails++; $display("[TB] FAIL pass_out_cnt got %0d want 3", out_cnt); end
    nChecks++; if (timedOut) begin nFails++; $display("[TB] FAIL pass_timeout got 1 want 0"); end
  endtask

  task automatic test_run_expand();
    doReset(0);
    inWords = '{16'h0005, 16'h8003};
    buildModel(0);
    applyStimulus(0, 1'b0);
    nChecks++; if (gotData.size() != expData.size()) begin nFails++; $display("[TB] FAIL run_count got %0d want %0d", gotData.size(), expData.size()); end
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      nChecks++; if (gotData[i] !== expData[i]) begin nFails++; $display("[TB] FAIL run_data[%0d] got %0h want %0h", i, gotData[i], expData[i]); end
    end
    nChecks++; if (readyLowCnt != 3) begin nFails++; $display("[TB] FAIL run_in_ready_low got %0d cycles want 3", readyLowCnt); end
    nChecks++; if (out_cnt !== 32'd4) begin nFails++; $display("[TB] FAIL run_out_cnt got %0d want 4", out_cnt); end
  endtask

  task automatic test_backpressure();
    doReset(0);
    inWords = '{16'h0005, 16'h8003};
    buildModel(0);
    applyStimulus(1, 1'b0);
    nChecks++; if (gotData.size() != expData.size()) begin nFails++; $display("[TB] FAIL bp_count got %0d want %0d", gotData.size(), expData.size()); end
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      nChecks++; if (gotData[i] !== expData[i]) begin nFails++; $display("[TB] FAIL bp_data[%0d] got %0h want %0h", i, gotData[i], expData[i]); end
    end
    nChecks++; if (stableErrs != 0) begin nFails++; $display("[TB] FAIL bp_stability got %0d violations want 0", stableErrs); end
    nChecks++; if (out_cnt !== 32'd4) begin nFails++; $display("[TB] FAIL bp_out_cnt got %0d want 4", out_cnt); end
  endtask

  task automatic test_limit();
    doReset(3);
    inWords = '{16'h0007, 16'h8010};
    buildModel(3);
    applyStimulus(0, 1'b0);
    nChecks++; if (gotData.size() != expData.size()) begin nFails++; $display("[TB] FAIL limit_count got %0d want %0d", gotData.size(), expData.size()); end
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      nChecks++; if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
        nFails++; $display("[TB] FAIL limit_sample[%0d] got %0h/last%0b want %0h/last%0b", i, gotData[i], gotLast[i], expData[i], expLast[i]);
      end
    end
    nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL limit_done got %0b want 1", done); end
    nChecks++; if (bus.in_ready !== 1'b0) begin nFails++; $display("[TB] FAIL limit_in_ready got %0b want 0", bus.in_ready); end
    nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL limit_out_valid got %0b want 0", bus.out_valid); end
    nChecks++; if (out_cnt !== 32'd3) begin nFails++; $display("[TB] FAIL limit_out_cnt got %0d want 3", out_cnt); end
  endtask

  task automatic test_edge_words();
    doReset(0);
    inWords = '{16'h8002, 16'h8000, 16'h0009};
    buildModel(0);
    applyStimulus(0, 1'b0);
    nChecks++; if (gotData.size() != expData.size()) begin nFails++; $display("[TB] FAIL edge_count got %0d want %0d", gotData.size(), expData.size()); end
    for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
      nChecks++; if (gotData[i] !== expData[i]) begin nFails++; $display("[TB] FAIL edge_data[%0d] got %0h want %0h", i, gotData[i], expData[i]); end
    end
    nChecks++; if (sentCnt != 3) begin nFails++; $display("[TB] FAIL edge_words_taken got %0d want 3", sentCnt); end
    nChecks++; if (out_cnt !== 32'd3) begin nFails++; $display("[TB] FAIL edge_out_cnt got %0d want 3", out_cnt); end
  endtask

  task automatic test_clear();
    int idx = 0;
    int hs = 0;
    int cyc = 0;
    doReset(0);
    inWords = '{16'h0004, 16'h8100};
    while (hs < 10 && cyc < 200) begin
      @(negedge core_clk);
      bus.in_valid  = (idx < 2);
      bus.in_data   = (idx < 2) ? inWords[idx] : 16'h0;
      bus.out_ready = 1'b1;
      #1;
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) hs++;
      cyc++;
    end
    nChecks++; if (hs != 10) begin nFails++; $display("[TB] FAIL clear_reach got %0d samples want 10", hs); end
    @(negedge core_clk);
    bus.in_valid = 1'b0;
    clear = 1'b1;
    #1;
    nChecks++; if (out_cnt !== 32'd10) begin nFails++; $display("[TB] FAIL clear_pre_cnt got %0d want 10", out_cnt); end
    @(negedge core_clk);
    clear = 1'b0;
    #1;
    nChecks++; if (bus.out_valid !== 1'b0) begin nFails++; $display("[TB] FAIL clear_out_valid got %0b want 0", bus.out_valid); end
    nChecks++; if (out_cnt !== 32'd0) begin nFails++; $display("[TB] FAIL clear_out_cnt got %0d want 0", out_cnt); end
    nChecks++; if (bus.in_ready !== 1'b1) begin nFails++; $display("[TB] FAIL clear_in_ready got %0b want 1", bus.in_ready); end
    inWords = '{16'h0001};
    buildModel(0);
    applyStimulus(0, 1'b0);
    nChecks++; if (gotData.size() != 1 || gotData[0] !== expData[0]) begin
      nFails++; $display("[TB] FAIL clear_after got %0d samples first %0h want 1 sample %0h", gotData.size(), (gotData.size() > 0) ? gotData[0] : 15'h0, expData[0]);
    end
    nChecks++; if (out_cnt !== 32'd1) begin nFails++; $display("[TB] FAIL clear_after_cnt got %0d want 1", out_cnt); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 15; it++) begin
      int n;
      int full;
      int lim;
      bit expDone;
      inWords.delete();
      n = $urandom_range(3, 10);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 2) == 0) inWords.push_back({1'b1, 15'($urandom_range(0, 6))});
        else inWords.push_back({1'b0, 15'($urandom_range(0, 32767))});
      end
      buildModel(0);
      full = expData.size();
      lim = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, full + 3)) : 0;
      expDone = (lim != 0) && (full >= lim);
      buildModel(lim);
      doReset(32'(lim));
      applyStimulus(2, 1'b1);
      nChecks++; if (gotData.size() != expData.size() || timedOut) begin
        nFails++; $display("[TB] FAIL rand%0d_count got %0d timeout %0b want %0d", it, gotData.size(), timedOut, expData.size());
      end
      for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
        nChecks++; if (gotData[i] !== expData[i] || gotLast[i] !== expLast[i]) begin
          nFails++; $display("[TB] FAIL rand%0d_sample[%0d] got %0h/last%0b want %0h/last%0b", it, i, gotData[i], gotLast[i], expData[i], expLast[i]);
        end
      end
      nChecks++; if (out_cnt !== 32'(expData.size()) || done !== expDone) begin
        nFails++; $display("[TB] FAIL rand%0d_status got cnt %0d done %0b want cnt %0d done %0b", it, out_cnt, done, expData.size(), expDone);
      end
      nChecks++; if (stableErrs != 0) begin nFails++; $display("[TB] FAIL rand%0d_stability got %0d violations want 0", it, stableErrs); end
    end
  endtask

  // Scenario order matters only in that each task starts from its own reset.
  initial begin
    test_reset();
    test_passthrough();
    test_run_expand();
    test_backpressure();
    test_limit();
    test_edge_words();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
